// File: rtl/noc_flat_pipe_bridge.sv
// Flat endpoint <-> NoC local-port bridge: LAT-deep flit/credit pipes plus per-VC credit policing.
// Define NOC_FLAT_STATS_EN to build the per-endpoint injected/ejected flit counters.
module noc_flat_pipe_bridge #(
    parameter int NE   = 16,
    parameter int V    = 2,
    parameter int Fpay = 32,
    parameter int B    = 4,
    parameter int LAT  = 1,
    localparam int Fw  = 2 + V + Fpay,
    localparam int CW  = $clog2(B + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NE*Fw-1:0]  ep_flit_in_all,
    input  logic [NE-1:0]     ep_flit_in_wr_all,
    output logic [NE*V-1:0]   ep_credit_out_all,
    output logic [NE*Fw-1:0]  ep_flit_out_all,
    output logic [NE-1:0]     ep_flit_out_wr_all,
    input  logic [NE*V-1:0]   ep_credit_in_all,
    output logic [NE*Fw-1:0]  noc_flit_out_all,
    output logic [NE-1:0]     noc_flit_out_wr_all,
    input  logic [NE*V-1:0]   noc_credit_in_all,
    input  logic [NE*Fw-1:0]  noc_flit_in_all,
    input  logic [NE-1:0]     noc_flit_in_wr_all,
    output logic [NE*V-1:0]   noc_credit_out_all,
    output logic [NE-1:0]     credit_err_all,
    output logic [NE*32-1:0]  stat_inj_all,
    output logic [NE*32-1:0]  stat_ej_all
);

    logic [NE-1:0][Fw-1:0] ep_flit_v;
    logic [NE-1:0][Fw-1:0] noc_flit_v;

    assign ep_flit_v  = ep_flit_in_all;
    assign noc_flit_v = noc_flit_in_all;

    // Saturating credit step; result is {protocol error, next count}.
    function automatic logic [CW:0] credit_step(input logic [CW-1:0] cnt,
                                                input logic take, input logic give);
        logic [CW:0] r;
        r = {1'b0, cnt};
        if (take && !give)
            r = (cnt == '0) ? {1'b1, cnt} : {1'b0, cnt - CW'(1)};
        else if (give && !take)
            r = (cnt == CW'(B)) ? {1'b1, cnt} : {1'b0, cnt + CW'(1)};
        return r;
    endfunction

    generate
        if (LAT == 0) begin : g_comb
            // Pure pass-through; reset only forces the outputs quiet.
            always_comb begin
                noc_flit_out_all    = reset ? ep_flit_v : '0;
                noc_flit_out_wr_all = reset ? ep_flit_in_wr_all : '0;
                ep_flit_out_all     = reset ? noc_flit_v : '0;
                ep_flit_out_wr_all  = reset ? noc_flit_in_wr_all : '0;
                ep_credit_out_all   = reset ? noc_credit_in_all : '0;
                noc_credit_out_all  = reset ? ep_credit_in_all : '0;
            end
        end else begin : g_pipe
            logic [LAT-1:0][NE-1:0][Fw-1:0] inj_flit_p, ej_flit_p;
            logic [LAT-1:0][NE-1:0]         inj_vld_p, ej_vld_p;
            logic [LAT-1:0][NE*V-1:0]       up_cr_p, dn_cr_p;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    inj_flit_p <= '0;
                    ej_flit_p  <= '0;
                    inj_vld_p  <= '0;
                    ej_vld_p   <= '0;
                    up_cr_p    <= '0;
                    dn_cr_p    <= '0;
                end else begin
                    // stage 0: capture the port inputs
                    inj_vld_p[0] <= ep_flit_in_wr_all;
                    ej_vld_p[0]  <= noc_flit_in_wr_all;
                    up_cr_p[0]   <= noc_credit_in_all;
                    dn_cr_p[0]   <= ep_credit_in_all;
                    for (int i = 0; i < NE; i++) begin
                        if (ep_flit_in_wr_all[i])  inj_flit_p[0][i] <= ep_flit_v[i];
                        if (noc_flit_in_wr_all[i]) ej_flit_p[0][i]  <= noc_flit_v[i];
                    end
                    // stages 1..LAT-1: shift, flit data moves only with its valid
                    for (int s = 1; s < LAT; s++) begin
                        inj_vld_p[s] <= inj_vld_p[s-1];
                        ej_vld_p[s]  <= ej_vld_p[s-1];
                        up_cr_p[s]   <= up_cr_p[s-1];
                        dn_cr_p[s]   <= dn_cr_p[s-1];
                        for (int i = 0; i < NE; i++) begin
                            if (inj_vld_p[s-1][i]) inj_flit_p[s][i] <= inj_flit_p[s-1][i];
                            if (ej_vld_p[s-1][i])  ej_flit_p[s][i]  <= ej_flit_p[s-1][i];
                        end
                    end
                end
            end

            assign noc_flit_out_all    = inj_flit_p[LAT-1];
            assign noc_flit_out_wr_all = inj_vld_p[LAT-1];
            assign ep_flit_out_all     = ej_flit_p[LAT-1];
            assign ep_flit_out_wr_all  = ej_vld_p[LAT-1];
            assign ep_credit_out_all   = up_cr_p[LAT-1];
            assign noc_credit_out_all  = dn_cr_p[LAT-1];
        end
    endgenerate

    logic [NE-1:0][V-1:0][CW-1:0] credit_cnt;
    logic [NE-1:0][V-1:0][CW-1:0] cnt_nxt;
    logic [NE-1:0][V-1:0][CW:0]   cnt_step;
    logic [NE-1:0]                inj_ok;
    logic [NE-1:0]                err_set;

    // Returns are the credits leaving the pipe toward the endpoint, not the raw NoC input.
    always_comb begin
        cnt_nxt  = credit_cnt;
        cnt_step = '0;
        inj_ok   = '0;
        err_set  = '0;
        for (int i = 0; i < NE; i++) begin
            inj_ok[i]  = ep_flit_in_wr_all[i] && $onehot(ep_flit_v[i][Fpay +: V]);
            err_set[i] = ep_flit_in_wr_all[i] && !inj_ok[i];
            for (int v = 0; v < V; v++) begin
                cnt_step[i][v] = credit_step(credit_cnt[i][v],
                                             inj_ok[i] && ep_flit_v[i][Fpay + v],
                                             ep_credit_out_all[i*V + v]);
                cnt_nxt[i][v]  = cnt_step[i][v][CW-1:0];
                err_set[i]     = err_set[i] | cnt_step[i][v][CW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NE; i++)
                for (int v = 0; v < V; v++)
                    credit_cnt[i][v] <= CW'(B);
            credit_err_all <= '0;
        end else begin
            credit_cnt     <= cnt_nxt;
            credit_err_all <= credit_err_all | err_set;
        end
    end

`ifdef NOC_FLAT_STATS_EN
    logic [NE-1:0][31:0] stat_inj_q;
    logic [NE-1:0][31:0] stat_ej_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_inj_q <= '0;
            stat_ej_q  <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                stat_inj_q[i] <= stat_inj_q[i] + 32'(ep_flit_in_wr_all[i]);
                stat_ej_q[i]  <= stat_ej_q[i] + 32'(ep_flit_out_wr_all[i]);
            end
        end
    end

    assign stat_inj_all = stat_inj_q;
    assign stat_ej_all  = stat_ej_q;
`else
    assign stat_inj_all = '0;
    assign stat_ej_all  = '0;
`endif

endmodule

// File: tb/tb_noc_flat_pipe_bridge.sv
// Bench for noc_flat_pipe_bridge: three instances (LAT 0/2/4) share random stimulus and are
// checked every cycle against a cycle-history model of the bridge.
module tb_noc_flat_pipe_bridge;

    localparam int NE = 8, V = 2, FPAY = 8, B = 4;
    localparam int FW = 2 + V + FPAY;
    localparam int CW = $clog2(B + 1);
    localparam int NC = 4000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NE*FW-1:0] ep_flit_in, noc_flit_in;
    logic [NE-1:0]    ep_wr_in, noc_wr_in;
    logic [NE*V-1:0]  ep_cr_in, noc_cr_in;

    wire [NE*FW-1:0]   o_noc_flit [3];
    wire [NE*FW-1:0]   o_ep_flit  [3];
    wire [NE-1:0]      o_noc_wr   [3];
    wire [NE-1:0]      o_ep_wr    [3];
    wire [NE*V-1:0]    o_ep_cr    [3];
    wire [NE*V-1:0]    o_noc_cr   [3];
    wire [NE-1:0]      o_err      [3];
    wire [NE*32-1:0]   o_inj      [3];
    wire [NE*32-1:0]   o_ej       [3];
    wire [NE*V*CW-1:0] cnt_w      [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    noc_flat_pipe_bridge #(.NE(NE), .V(V), .Fpay(FPAY), .B(B), .LAT(0)) d0 (
        .clk(clk), .reset(reset),
        .ep_flit_in_all(ep_flit_in), .ep_flit_in_wr_all(ep_wr_in), .ep_credit_out_all(o_ep_cr[0]),
        .ep_flit_out_all(o_ep_flit[0]), .ep_flit_out_wr_all(o_ep_wr[0]), .ep_credit_in_all(ep_cr_in),
        .noc_flit_out_all(o_noc_flit[0]), .noc_flit_out_wr_all(o_noc_wr[0]), .noc_credit_in_all(noc_cr_in),
        .noc_flit_in_all(noc_flit_in), .noc_flit_in_wr_all(noc_wr_in), .noc_credit_out_all(o_noc_cr[0]),
        .credit_err_all(o_err[0]), .stat_inj_all(o_inj[0]), .stat_ej_all(o_ej[0]));

    noc_flat_pipe_bridge #(.NE(NE), .V(V), .Fpay(FPAY), .B(B), .LAT(2)) d2 (
        .clk(clk), .reset(reset),
        .ep_flit_in_all(ep_flit_in), .ep_flit_in_wr_all(ep_wr_in), .ep_credit_out_all(o_ep_cr[1]),
        .ep_flit_out_all(o_ep_flit[1]), .ep_flit_out_wr_all(o_ep_wr[1]), .ep_credit_in_all(ep_cr_in),
        .noc_flit_out_all(o_noc_flit[1]), .noc_flit_out_wr_all(o_noc_wr[1]), .noc_credit_in_all(noc_cr_in),
        .noc_flit_in_all(noc_flit_in), .noc_flit_in_wr_all(noc_wr_in), .noc_credit_out_all(o_noc_cr[1]),
        .credit_err_all(o_err[1]), .stat_inj_all(o_inj[1]), .stat_ej_all(o_ej[1]));

    noc_flat_pipe_bridge #(.NE(NE), .V(V), .Fpay(FPAY), .B(B), .LAT(4)) d4 (
        .clk(clk), .reset(reset),
        .ep_flit_in_all(ep_flit_in), .ep_flit_in_wr_all(ep_wr_in), .ep_credit_out_all(o_ep_cr[2]),
        .ep_flit_out_all(o_ep_flit[2]), .ep_flit_out_wr_all(o_ep_wr[2]), .ep_credit_in_all(ep_cr_in),
        .noc_flit_out_all(o_noc_flit[2]), .noc_flit_out_wr_all(o_noc_wr[2]), .noc_credit_in_all(noc_cr_in),
        .noc_flit_in_all(noc_flit_in), .noc_flit_in_wr_all(noc_wr_in), .noc_credit_out_all(o_noc_cr[2]),
        .credit_err_all(o_err[2]), .stat_inj_all(o_inj[2]), .stat_ej_all(o_ej[2]));

    assign cnt_w[0] = d0.credit_cnt;
    assign cnt_w[1] = d2.credit_cnt;
    assign cnt_w[2] = d4.credit_cnt;

    // Input history per cycle; h_rst[c] is the reset level held through cycle c.
    bit [NE*FW-1:0] h_epf [NC];
    bit [NE*FW-1:0] h_nocf[NC];
    bit [NE-1:0]    h_epw [NC];
    bit [NE-1:0]    h_nocw[NC];
    bit [NE*V-1:0]  h_epc [NC];
    bit [NE*V-1:0]  h_nocc[NC];
    bit             h_rst [NC];

    int       mcnt [3][NE][V];
    bit       merr [3][NE];
    bit [31:0] minj[3][NE];
    bit [31:0] mej [3][NE];

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 4);
    endfunction

    // An output seen in cycle c carries the input of cycle c-L only if reset stayed high throughout.
    function automatic bit live(input int L, input int c);
        for (int j = 0; j <= L; j++)
            if (c - j < 1 || c - j >= NC || !h_rst[c-j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NE*V-1:0] exp_ep_cr(input int k, input int c);
        int L = lat_of(k);
        return live(L, c) ? h_nocc[c-L] : '0;
    endfunction

    function automatic logic [NE-1:0] exp_ep_wr(input int k, input int c);
        int L = lat_of(k);
        return live(L, c) ? h_nocw[c-L] : '0;
    endfunction

    function automatic logic [FW-1:0] mkflit(input logic [V-1:0] vc, input logic [7:0] p);
        return {2'b01, vc, p};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NE; i++) begin
                merr[k][i] = 1'b0;
                minj[k][i] = '0;
                mej[k][i]  = '0;
                for (int v = 0; v < V; v++) mcnt[k][i][v] = B;
            end
    endtask

    task automatic compare_inst(input int k, input int c);
        int L;
        bit lv;
        int idx;
        logic [NE-1:0]      e_nw, e_ew, e_err;
        logic [NE*V-1:0]    e_nc, e_ec;
        logic [NE*FW-1:0]   e_nf, e_ef, a_nf, a_ef;
        logic [NE*V*CW-1:0] e_cnt;
        logic [NE*32-1:0]   e_inj, e_ej;
        L   = lat_of(k);
        lv  = live(L, c);
        idx = lv ? c - L : 0;
        e_nw = lv ? h_epw[idx]  : '0;
        e_ew = lv ? h_nocw[idx] : '0;
        e_nc = lv ? h_epc[idx]  : '0;
        e_ec = lv ? h_nocc[idx] : '0;
        e_nf = '0; e_ef = '0; a_nf = '0; a_ef = '0;
        if (!reset) begin
            a_nf = o_noc_flit[k];
            a_ef = o_ep_flit[k];
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (e_nw[i]) begin
                    e_nf[i*FW +: FW] = h_epf[idx][i*FW +: FW];
                    a_nf[i*FW +: FW] = o_noc_flit[k][i*FW +: FW];
                end
                if (e_ew[i]) begin
                    e_ef[i*FW +: FW] = h_nocf[idx][i*FW +: FW];
                    a_ef[i*FW +: FW] = o_ep_flit[k][i*FW +: FW];
                end
            end
        end
        e_inj = '0; e_ej = '0;
        for (int i = 0; i < NE; i++) begin
            e_err[i] = merr[k][i];
            for (int v = 0; v < V; v++) e_cnt[(i*V+v)*CW +: CW] = CW'(mcnt[k][i][v]);
`ifdef NOC_FLAT_STATS_EN
            e_inj[i*32 +: 32] = minj[k][i];
            e_ej[i*32 +: 32]  = mej[k][i];
`endif
        end
        chk($sformatf("noc_wr[L%0d]", L),   o_noc_wr[k], e_nw);
        chk($sformatf("ep_wr[L%0d]", L),    o_ep_wr[k],  e_ew);
        chk($sformatf("noc_cr[L%0d]", L),   o_noc_cr[k], e_nc);
        chk($sformatf("ep_cr[L%0d]", L),    o_ep_cr[k],  e_ec);
        chk($sformatf("noc_flit[L%0d]", L), a_nf, e_nf);
        chk($sformatf("ep_flit[L%0d]", L),  a_ef, e_ef);
        chk($sformatf("cnt[L%0d]", L),      cnt_w[k], e_cnt);
        chk($sformatf("err[L%0d]", L),      o_err[k], e_err);
        chk($sformatf("stat_inj[L%0d]", L), o_inj[k], e_inj);
        chk($sformatf("stat_ej[L%0d]", L),  o_ej[k],  e_ej);
    endtask

    // Record this cycle's inputs, then compare every instance against the model.
    always @(negedge clk) begin
        if (cyc < NC) begin
            h_epf[cyc]  = ep_flit_in;
            h_nocf[cyc] = noc_flit_in;
            h_epw[cyc]  = ep_wr_in;
            h_nocw[cyc] = noc_wr_in;
            h_epc[cyc]  = ep_cr_in;
            h_nocc[cyc] = noc_cr_in;
            h_rst[cyc]  = reset;
            if (!reset) model_reset();
            for (int k = 0; k < 3; k++) compare_inst(k, cyc);
        end
    end

    // Credit accounting from the rules: inject takes one, returned credit gives one back.
    always @(posedge clk) begin
        if (cyc < NC && h_rst[cyc]) begin
            for (int k = 0; k < 3; k++) begin
                logic [NE*V-1:0] ret;
                logic [NE-1:0]   ejw;
                ret = exp_ep_cr(k, cyc);
                ejw = exp_ep_wr(k, cyc);
                for (int i = 0; i < NE; i++) begin
                    logic [V-1:0] vc;
                    bit wr, good;
                    wr   = h_epw[cyc][i];
                    vc   = h_epf[cyc][i*FW+FPAY +: V];
                    good = ($countones(vc) == 1);
                    minj[k][i] = minj[k][i] + 32'(wr);
                    mej[k][i]  = mej[k][i] + 32'(ejw[i]);
                    if (wr && !good) merr[k][i] = 1'b1;
                    for (int v = 0; v < V; v++) begin
                        bit take, give;
                        take = wr && good && vc[v];
                        give = ret[i*V+v];
                        if (take && !give) begin
                            if (mcnt[k][i][v] == 0) merr[k][i] = 1'b1;
                            else mcnt[k][i][v]--;
                        end else if (give && !take) begin
                            if (mcnt[k][i][v] == B) merr[k][i] = 1'b1;
                            else mcnt[k][i][v]++;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ep_flit_in  = '0;
        noc_flit_in = '0;
        ep_wr_in    = '0;
        noc_wr_in   = '0;
        ep_cr_in    = '0;
        noc_cr_in   = '0;
    endtask

    function automatic logic [V-1:0] rand_vc();
        int r;
        r = $urandom_range(9);
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        return (r % 2) ? 2'b01 : 2'b10;
    endfunction

    initial begin
        logic [NE*V*CW-1:0] all_b;
        all_b = {NE*V{3'd4}};
        reset = 1'b0;
        idle();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_noc_wr", o_noc_wr[2], '0);
        chk("rst_cnt", cnt_w[1], all_b);
        chk("rst_err", o_err[2], '0);
        chk("rst_flit", o_ep_flit[1], '0);

        // Single flit on endpoint 3: same cycle at LAT 0, two cycles later at LAT 2.
        tick(); reset = 1'b1;
        tick(); ep_wr_in[3] = 1'b1; ep_flit_in[3*FW +: FW] = mkflit(2'b01, 8'hA5);
        @(negedge clk);
        chk("lat0_wr", o_noc_wr[0], 8'h08);
        chk("lat0_data", o_noc_flit[0][3*FW +: FW], 12'h5A5);
        tick(); idle();
        @(negedge clk);
        chk("lat2_early", o_noc_wr[1], 8'h00);
        tick();
        @(negedge clk);
        chk("lat2_wr", o_noc_wr[1], 8'h08);
        chk("lat2_data", o_noc_flit[1][3*FW +: FW], 12'h5A5);

        // LAT 0 credit passes straight through.
        tick(); noc_cr_in[5] = 1'b1;
        #1 chk("lat0_cr_hi", o_ep_cr[0][5], 1'b1);
        noc_cr_in[5] = 1'b0;
        #1 chk("lat0_cr_lo", o_ep_cr[0][5], 1'b0);

        // Five injections on ep0 VC0 with no returns; first one on the reset-release cycle.
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) tick();
            ep_wr_in[0] = 1'b1;
            ep_flit_in[0 +: FW] = mkflit(2'b01, 8'h10 + 8'(n));
        end
        @(negedge clk);
        chk("underflow_cnt4", cnt_w[1][0 +: CW], 3'd0);
        chk("underflow_err4", o_err[1][0], 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("underflow_err5", o_err[1][0], 1'b1);
        chk("underflow_cnt5", cnt_w[1][0 +: CW], 3'd0);
        tick();
        @(negedge clk);
        chk("underflow_fwd_wr", o_noc_wr[1][0], 1'b1);
        chk("underflow_fwd_data", o_noc_flit[1][0 +: FW], 12'h514);

        // ep1 VC1 at two credits, then inject and return together (LAT 0 instance).
        tick(); reset = 1'b0;
        tick(); reset = 1'b1; ep_wr_in[1] = 1'b1; ep_flit_in[FW +: FW] = mkflit(2'b10, 8'h21);
        tick();
        tick(); noc_cr_in[1*V+1] = 1'b1;
        @(negedge clk);
        chk("same_cycle_pre", cnt_w[0][(1*V+1)*CW +: CW], 3'd2);
        tick(); idle();
        @(negedge clk);
        chk("same_cycle_cnt", cnt_w[0][(1*V+1)*CW +: CW], 3'd2);
        chk("same_cycle_err", o_err[0][1], 1'b0);

        // Three flits in flight in the LAT 4 instance, then a reset pulse.
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick(); idle();
            ep_wr_in[n] = 1'b1;
            ep_flit_in[n*FW +: FW] = mkflit(2'b01, 8'h40 + 8'(n));
        end
        tick(); idle(); reset = 1'b0;
        @(negedge clk);
        chk("flush_rst_wr", o_noc_wr[2], '0);
        chk("flush_rst_flit", o_noc_flit[2], '0);
        chk("flush_rst_cr", o_ep_cr[2], '0);
        tick(); reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("flush_after_wr", o_noc_wr[2], '0);
            tick();
        end
        chk("flush_cnt", cnt_w[2], all_b);
        chk("flush_err", o_err[2], '0);

`ifdef NOC_FLAT_STATS_EN
        // Counter wrap: preload all inject counts of the LAT 2 instance, then one injection on ep0.
        force d2.stat_inj_q = {NE{32'hFFFF_FFFF}};
        for (int i = 0; i < NE; i++) minj[1][i] = 32'hFFFF_FFFF;
        tick();
        release d2.stat_inj_q;
        ep_wr_in[0] = 1'b1; ep_flit_in[0 +: FW] = mkflit(2'b01, 8'h77);
        tick(); idle();
        @(negedge clk);
        chk("stat_wrap", o_inj[1][0 +: 32], 32'h0);
        chk("stat_wrap_other", o_inj[1][32 +: 32], 32'hFFFF_FFFF);
`else
        @(negedge clk);
        chk("stat_off_inj", o_inj[1], '0);
        chk("stat_off_ej", o_ej[2], '0);
`endif

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 1500; n++) begin
            tick();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(199) == 0) reset = 1'b0;
            for (int i = 0; i < NE; i++) begin
                ep_wr_in[i]  = 1'($urandom_range(1));
                noc_wr_in[i] = 1'($urandom_range(1));
                ep_flit_in[i*FW +: FW]  = {2'($urandom), rand_vc(), 8'($urandom)};
                noc_flit_in[i*FW +: FW] = {2'($urandom), rand_vc(), 8'($urandom)};
            end
            for (int j = 0; j < NE*V; j++) begin
                ep_cr_in[j]  = ($urandom_range(3) == 0);
                noc_cr_in[j] = ($urandom_range(3) == 0);
            end
        end
        tick(); idle(); reset = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
